// File: rtl/scaler_pkg.sv
// Shared constants and types for the pitch scaler: frame geometry, word widths
// and the control FSM encoding.
package scaler_pkg;

    localparam int N_BINS    = 4096;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int STEP_FRAC = 8;
    localparam int RD_LAT    = 2;
    localparam int STEP_W    = 12;
    // Four integer guard bits above the bin index, so acc never wraps across a frame.
    localparam int ACC_W     = ADDR_W + STEP_FRAC + 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [ADDR_W-1:0] bin_addr_t;
    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [STEP_W-1:0] step_t;
    typedef logic [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/scaler_index_gen.sv
// Output-bin counter and fixed-point source accumulator. It produces the source
// bin floor(k*step/256) for the current output bin k.
module scaler_index_gen
    import scaler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [ADDR_W-1:0] k_o,
    output logic [ADDR_W-1:0] src_o,
    output logic              in_range_o,
    output logic              last_o
);

    bin_addr_t k_q, k_d;
    acc_t      acc_q, acc_d;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        k_d   = k_q;
        acc_d = acc_q;
        if (start_i) begin
            k_d   = '0;
            acc_d = '0;
        end else if (advance_i) begin
            k_d   = k_q + 1'b1;
            acc_d = acc_q + ACC_W'(step_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            k_q   <= k_d;
            acc_q <= acc_d;
        end
    end

    // The source is out of range as soon as any integer bit above the bin index is set.
    assign in_range_o = (acc_q[ACC_W-1:ADDR_W+STEP_FRAC] == '0);
    assign src_o      = in_range_o ? acc_q[ADDR_W+STEP_FRAC-1:STEP_FRAC] : '0;
    assign k_o        = k_q;
    assign last_o     = (k_q == ADDR_W'(N_BINS - 1));

endmodule

// File: rtl/pitch_scaler.sv
// Pitch scaler: remaps a polar frame from the selected ping-pong buffer pair into
// the shifted buffers. Output bin k takes source bin floor(k*step/256).
module pitch_scaler
    import scaler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              go_in,
    input  logic              cur_buf,
    input  logic [STEP_W-1:0] step_q,
    input  logic [DATA_W-1:0] mag_buf_0_data,
    output logic [ADDR_W-1:0] mag_buf_0_addr,
    input  logic [DATA_W-1:0] phase_buf_0_data,
    output logic [ADDR_W-1:0] phase_buf_0_addr,
    input  logic [DATA_W-1:0] mag_buf_1_data,
    output logic [ADDR_W-1:0] mag_buf_1_addr,
    input  logic [DATA_W-1:0] phase_buf_1_data,
    output logic [ADDR_W-1:0] phase_buf_1_addr,
    output logic [DATA_W-1:0] out_mag_data,
    output logic [ADDR_W-1:0] out_mag_addr,
    output logic              out_mag_wren,
    output logic [DATA_W-1:0] out_phase_data,
    output logic [ADDR_W-1:0] out_phase_addr,
    output logic              out_phase_wren,
    output logic              busy,
    output logic              go_out
);

    localparam int DRAIN_W = $clog2(RD_LAT + 1);

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 sel_q;
    step_t                step_l_q;
    logic                 start, issue;

    bin_addr_t            k, src;
    logic                 in_range, last;

    logic [RD_LAT-1:0]    vld_q;
    logic [RD_LAT-1:0]    rng_q;
    bin_addr_t            k_pipe_q [RD_LAT];

    bin_addr_t            rd_addr;
    sample_t              mag_sel, phase_sel;
    logic                 wr_vld, wr_rng;

    scaler_index_gen u_index_gen (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .advance_i  (issue),
        .step_i     (step_l_q),
        .k_o        (k),
        .src_o      (src),
        .in_range_o (in_range),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        start   = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go_in) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(RD_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            sel_q    <= 1'b0;
            step_l_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (start) begin
                sel_q    <= cur_buf;
                step_l_q <= step_q;
            end
        end
    end

    // Control side of the read-latency pipeline; cleared by reset so an aborted frame writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            rng_q <= '0;
        end else begin
            vld_q[0] <= issue;
            rng_q[0] <= in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                rng_q[i] <= rng_q[i-1];
            end
        end
    end

    // NOTE: the delayed bin index is plain datapath qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        k_pipe_q[0] <= k;
        for (int i = 1; i < RD_LAT; i++) begin
            k_pipe_q[i] <= k_pipe_q[i-1];
        end
    end

    assign rd_addr          = issue ? src : '0;
    assign mag_buf_0_addr   = rd_addr;
    assign phase_buf_0_addr = rd_addr;
    assign mag_buf_1_addr   = rd_addr;
    assign phase_buf_1_addr = rd_addr;

    // Data is steered by the pair latched at start, never by the live cur_buf.
    assign mag_sel   = sel_q ? mag_buf_1_data   : mag_buf_0_data;
    assign phase_sel = sel_q ? phase_buf_1_data : phase_buf_0_data;

    assign wr_vld = vld_q[RD_LAT-1];
    assign wr_rng = rng_q[RD_LAT-1];

    assign out_mag_wren   = wr_vld;
    assign out_phase_wren = wr_vld;
    assign out_mag_addr   = wr_vld ? k_pipe_q[RD_LAT-1] : '0;
    assign out_phase_addr = wr_vld ? k_pipe_q[RD_LAT-1] : '0;
    assign out_mag_data   = (wr_vld && wr_rng) ? mag_sel   : '0;
    assign out_phase_data = (wr_vld && wr_rng) ? phase_sel : '0;

    assign busy   = (state_q == RUN) || (state_q == DRAIN);
    assign go_out = (state_q == DONE);

endmodule

// File: tb/tb_pitch_scaler.sv
// Directed bench for pitch_scaler: buffer models with two-cycle read latency, a
// write monitor, and one task per scenario with hand-derived expectations.
module tb_pitch_scaler;
    import scaler_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              go_in;
    logic              cur_buf;
    logic [STEP_W-1:0] step_q;
    logic [DATA_W-1:0] mag_buf_0_data, phase_buf_0_data, mag_buf_1_data, phase_buf_1_data;
    logic [ADDR_W-1:0] mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr;
    logic [DATA_W-1:0] out_mag_data, out_phase_data;
    logic [ADDR_W-1:0] out_mag_addr, out_phase_addr;
    logic              out_mag_wren, out_phase_wren;
    logic              busy, go_out;

    pitch_scaler dut (
        .clk              (clk),
        .reset            (reset),
        .go_in            (go_in),
        .cur_buf          (cur_buf),
        .step_q           (step_q),
        .mag_buf_0_data   (mag_buf_0_data),
        .mag_buf_0_addr   (mag_buf_0_addr),
        .phase_buf_0_data (phase_buf_0_data),
        .phase_buf_0_addr (phase_buf_0_addr),
        .mag_buf_1_data   (mag_buf_1_data),
        .mag_buf_1_addr   (mag_buf_1_addr),
        .phase_buf_1_data (phase_buf_1_data),
        .phase_buf_1_addr (phase_buf_1_addr),
        .out_mag_data     (out_mag_data),
        .out_mag_addr     (out_mag_addr),
        .out_mag_wren     (out_mag_wren),
        .out_phase_data   (out_phase_data),
        .out_phase_addr   (out_phase_addr),
        .out_phase_wren   (out_phase_wren),
        .busy             (busy),
        .go_out           (go_out)
    );

    always #5 clk = ~clk;

    // Source buffers with a two-cycle address-to-data latency.
    logic [DATA_W-1:0] mag0_mem [N_BINS];
    logic [DATA_W-1:0] ph0_mem  [N_BINS];
    logic [DATA_W-1:0] mag1_mem [N_BINS];
    logic [DATA_W-1:0] ph1_mem  [N_BINS];
    logic [DATA_W-1:0] m0_r1, m0_r2, p0_r1, p0_r2, m1_r1, m1_r2, p1_r1, p1_r2;

    always @(posedge clk) begin
        m0_r1 <= mag0_mem[mag_buf_0_addr];   m0_r2 <= m0_r1;
        p0_r1 <= ph0_mem[phase_buf_0_addr];  p0_r2 <= p0_r1;
        m1_r1 <= mag1_mem[mag_buf_1_addr];   m1_r2 <= m1_r1;
        p1_r1 <= ph1_mem[phase_buf_1_addr];  p1_r2 <= p1_r1;
    end
    assign mag_buf_0_data   = m0_r2;
    assign phase_buf_0_data = p0_r2;
    assign mag_buf_1_data   = m1_r2;
    assign phase_buf_1_data = p1_r2;

    // Shifted-buffer capture and per-frame bookkeeping.
    logic [DATA_W-1:0] got_mag [N_BINS];
    logic [DATA_W-1:0] got_ph  [N_BINS];
    int cyc = 0;
    int t0 = 0;
    int rel;
    bit mon_en = 1'b0;
    bit busy_chk = 1'b0;
    int wr_cnt, wr_gap_err, wr_win_err, goout_cnt, goout_rel, busy_err;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rel = cyc - t0;
        if (mon_en) begin
            if (out_mag_wren) begin
                if (rel != 3 + wr_cnt || out_mag_addr != ADDR_W'(wr_cnt)) wr_gap_err++;
                if (out_phase_wren !== 1'b1 || out_phase_addr !== out_mag_addr) wr_gap_err++;
                if (rel < 3 || rel > 4098) wr_win_err++;
                got_mag[out_mag_addr] = out_mag_data;
                got_ph[out_phase_addr] = out_phase_data;
                wr_cnt++;
            end else if (out_phase_wren) begin
                wr_gap_err++;
            end
            if (go_out) begin
                goout_cnt++;
                goout_rel = rel;
            end
            if (busy_chk && rel >= 1 && rel <= 4110 && busy !== (rel >= 1 && rel <= 4098)) busy_err++;
        end
    end

    function automatic logic [DATA_W-1:0] exp_mag(input bit pair, input int step, input int k);
        int src;
        src = (k * step) >> 8;
        if (src >= N_BINS) return '0;
        return pair ? mag1_mem[src] : mag0_mem[src];
    endfunction

    function automatic logic [DATA_W-1:0] exp_ph(input bit pair, input int step, input int k);
        int src;
        src = (k * step) >> 8;
        if (src >= N_BINS) return '0;
        return pair ? ph1_mem[src] : ph0_mem[src];
    endfunction

    // Called at a falling edge; returns one cycle after go_in was sampled (relative cycle 1).
    task automatic begin_frame(input int step, input bit pair);
        wr_cnt = 0; wr_gap_err = 0; wr_win_err = 0;
        goout_cnt = 0; goout_rel = -1; busy_err = 0;
        for (int k = 0; k < N_BINS; k++) begin
            got_mag[k] = 'x;
            got_ph[k]  = 'x;
        end
        step_q   = STEP_W'(step);
        cur_buf  = pair;
        t0       = cyc;
        busy_chk = 1'b1;
        mon_en   = 1'b1;
        go_in    = 1'b1;
        @(negedge clk);
        go_in    = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4300 && goout_cnt == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [107:0] all_out;
        reset = 1'b1; go_in = 1'b0; cur_buf = 1'b0; step_q = 12'd256;
        repeat (3) @(negedge clk);
        all_out = {mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr,
                   out_mag_data, out_mag_addr, out_mag_wren,
                   out_phase_data, out_phase_addr, out_phase_wren, busy, go_out};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        all_out = {mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr,
                   out_mag_data, out_mag_addr, out_mag_wren,
                   out_phase_data, out_phase_addr, out_phase_wren, busy, go_out};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_identity();
        int bad_m, bad_p;
        begin_frame(256, 1'b0);
        wait_done();
        bad_m = 0; bad_p = 0;
        for (int k = 0; k < N_BINS; k++) begin
            if (got_mag[k] !== DATA_W'(k)) bad_m++;
            if (got_ph[k] !== (16'h8000 ^ DATA_W'(k))) bad_p++;
        end
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL ident_writes: got %0d expected 4096", wr_cnt); end
        n_checks++; if (wr_gap_err !== 0) begin n_fail++; $display("FAIL ident_order: got %0d errors expected 0", wr_gap_err); end
        n_checks++; if (wr_win_err !== 0) begin n_fail++; $display("FAIL ident_window: got %0d errors expected 0", wr_win_err); end
        n_checks++; if (goout_cnt !== 1) begin n_fail++; $display("FAIL ident_goout_count: got %0d expected 1", goout_cnt); end
        n_checks++; if (goout_rel !== 4099) begin n_fail++; $display("FAIL ident_goout_cycle: got %0d expected 4099", goout_rel); end
        n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL ident_busy: got %0d bad cycles expected 0", busy_err); end
        n_checks++; if (bad_m !== 0) begin n_fail++; $display("FAIL ident_mag: got %0d bad bins expected 0", bad_m); end
        n_checks++; if (bad_p !== 0) begin n_fail++; $display("FAIL ident_phase: got %0d bad bins expected 0", bad_p); end
        n_checks++; if (got_ph[4095] !== 16'h8FFF) begin n_fail++; $display("FAIL ident_phase_last: got %h expected 8fff", got_ph[4095]); end
    endtask

    task automatic test_octave_up();
        int bad;
        begin_frame(128, 1'b0);
        wait_done();
        bad = 0;
        for (int k = 0; k < N_BINS; k++) begin
            if (got_mag[k] !== exp_mag(1'b0, 128, k) || got_ph[k] !== exp_ph(1'b0, 128, k)) bad++;
        end
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL up_writes: got %0d expected 4096", wr_cnt); end
        n_checks++; if (got_mag[7] !== 16'd3) begin n_fail++; $display("FAIL up_bin7: got %0d expected 3", got_mag[7]); end
        n_checks++; if (got_mag[4095] !== 16'd2047) begin n_fail++; $display("FAIL up_bin4095: got %0d expected 2047", got_mag[4095]); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL up_all_bins: got %0d bad bins expected 0", bad); end
        n_checks++; if (goout_cnt !== 1) begin n_fail++; $display("FAIL up_goout_count: got %0d expected 1", goout_cnt); end
    endtask

    task automatic test_octave_down();
        int bad, bad_hi;
        begin_frame(512, 1'b0);
        wait_done();
        bad = 0; bad_hi = 0;
        for (int k = 0; k < 2048; k++) begin
            if (got_mag[k] !== DATA_W'(2 * k) || got_ph[k] !== (16'h8000 ^ DATA_W'(2 * k))) bad++;
        end
        for (int k = 2048; k < N_BINS; k++) begin
            if (got_mag[k] !== '0 || got_ph[k] !== '0) bad_hi++;
        end
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL down_writes: got %0d expected 4096", wr_cnt); end
        n_checks++; if (got_ph[5] !== 16'h800A) begin n_fail++; $display("FAIL down_phase5: got %h expected 800a", got_ph[5]); end
        n_checks++; if (got_mag[2047] !== 16'd4094) begin n_fail++; $display("FAIL down_bin2047: got %0d expected 4094", got_mag[2047]); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL down_low_bins: got %0d bad bins expected 0", bad); end
        n_checks++; if (bad_hi !== 0) begin n_fail++; $display("FAIL down_zero_bins: got %0d nonzero bins expected 0", bad_hi); end
        n_checks++; if (goout_rel !== 4099) begin n_fail++; $display("FAIL down_goout_cycle: got %0d expected 4099", goout_rel); end
    endtask

    task automatic test_buffer_select();
        int bad;
        begin_frame(256, 1'b1);
        repeat (49) @(negedge clk);
        cur_buf = 1'b0;
        step_q  = 12'd512;
        wait_done();
        bad = 0;
        for (int k = 0; k < N_BINS; k++) begin
            if (got_mag[k] !== mag1_mem[k] || got_ph[k] !== ph1_mem[k]) bad++;
        end
        n_checks++; if (got_mag[10] !== 16'hA032) begin n_fail++; $display("FAIL sel_bin10: got %h expected a032", got_mag[10]); end
        n_checks++; if (got_ph[4000] !== 16'h21D4) begin n_fail++; $display("FAIL sel_phase4000: got %h expected 21d4", got_ph[4000]); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sel_all_bins: got %0d bad bins expected 0", bad); end
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL sel_writes: got %0d expected 4096", wr_cnt); end
    endtask

    task automatic test_busy_protect();
        int bad;
        begin_frame(256, 1'b0);
        repeat (99) @(negedge clk);
        go_in  = 1'b1;
        step_q = 12'd64;
        @(negedge clk);
        go_in  = 1'b0;
        wait_done();
        bad = 0;
        for (int k = 0; k < N_BINS; k++) begin
            if (got_mag[k] !== DATA_W'(k)) bad++;
        end
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL busy_writes: got %0d expected 4096", wr_cnt); end
        n_checks++; if (goout_cnt !== 1) begin n_fail++; $display("FAIL busy_goout_count: got %0d expected 1", goout_cnt); end
        n_checks++; if (goout_rel !== 4099) begin n_fail++; $display("FAIL busy_goout_cycle: got %0d expected 4099", goout_rel); end
        n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL busy_window: got %0d bad cycles expected 0", busy_err); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL busy_data: got %0d bad bins expected 0", bad); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [107:0] all_out;
        begin_frame(256, 1'b0);
        repeat (1999) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        busy_chk = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        all_out = {mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr,
                   out_mag_data, out_mag_addr, out_mag_wren,
                   out_phase_data, out_phase_addr, out_phase_wren, busy, go_out};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h expected 0", all_out);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        n_checks++; if (goout_cnt !== 0) begin n_fail++; $display("FAIL midrst_goout: got %0d expected 0", goout_cnt); end
        n_checks++; if (wr_cnt !== 1998) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 1998", wr_cnt); end
        @(negedge clk);
        begin_frame(256, 1'b0);
        wait_done();
        n_checks++; if (wr_cnt !== 4096) begin n_fail++; $display("FAIL midrst_new_writes: got %0d expected 4096", wr_cnt); end
        n_checks++; if (goout_rel !== 4099) begin n_fail++; $display("FAIL midrst_new_goout: got %0d expected 4099", goout_rel); end
        n_checks++; if (got_mag[1234] !== 16'd1234) begin n_fail++; $display("FAIL midrst_new_data: got %0d expected 1234", got_mag[1234]); end
    endtask

    initial begin
        for (int i = 0; i < N_BINS; i++) begin
            mag0_mem[i] = DATA_W'(i);
            ph0_mem[i]  = 16'h8000 ^ DATA_W'(i);
            mag1_mem[i] = 16'hA000 ^ DATA_W'(i * 5);
            ph1_mem[i]  = 16'h1234 + DATA_W'(i);
        end
        test_reset();
        test_identity();
        test_octave_up();
        test_octave_down();
        test_buffer_select();
        test_busy_protect();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
